// File: rtl/uart_rx_core.sv
// UART receive engine: runtime parity/stop-bit selection, 3-sample majority vote, valid/ready output.
// Optional break detection with WAIT_IDLE recovery is enabled by defining UART_RX_BREAK_DET_EN.
`timescale 1ns/1ps
module uart_rx_core #(
  parameter int DataLength      = 8,
  parameter int OverSample      = 8,
  parameter int BaudRate        = 115200,
  parameter int SystemClockFreq = 50_000_000,
  parameter int SyncStages      = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx,
  input  logic                  i_parity_en,
  input  logic                  i_parity_odd,
  input  logic                  i_two_stop,
  output logic [DataLength-1:0] o_rx_data,
  output logic                  o_rx_valid,
  input  logic                  i_rx_ready,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_break,
  output logic                  o_overrun,
  output logic                  o_busy
);
  localparam int Div  = (SystemClockFreq + (BaudRate * OverSample) / 2) / (BaudRate * OverSample);
  localparam int DivW = $clog2(Div) + 1;
  localparam int CntW = $clog2(OverSample) + 1;
  localparam int BitW = $clog2(DataLength) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
`ifdef UART_RX_BREAK_DET_EN
    , S_WAIT_IDLE
`endif
  } state_t;

  state_t                r_state;
  logic [DivW-1:0]       r_div_cnt;
  logic [SyncStages-1:0] r_sync;
  logic [CntW-1:0]       r_tick_cnt;
  logic [BitW-1:0]       r_bit_cnt;
  logic [DataLength-1:0] r_shift;
  logic                  r_s0, r_s1;
  logic                  r_par_en, r_par_odd, r_two_stop;
  logic                  r_par_err, r_frame_err;
`ifdef UART_RX_BREAK_DET_EN
  logic                  r_par_bit;
`endif
  logic [DataLength-1:0] r_data;
  logic                  r_valid, r_perr, r_ferr, r_brk, r_overrun, r_busy;

  logic            w_tick, w_rx, w_maj, w_mid_lo, w_mid, w_mid_hi;
  logic            w_complete, w_brk, w_ferr_fin;
  logic [CntW-1:0] w_cnt_nxt;

  // Divider counts down and fires on zero, giving one tick every Div cycles.
  assign w_tick = (r_div_cnt == '0);
  always_ff @(posedge i_clk) begin
    if (i_rst)       r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= DivW'(Div - 1);
    else             r_div_cnt <= r_div_cnt - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= '1;
    else       r_sync <= {r_sync[SyncStages-2:0], i_rx};
  end
  assign w_rx = r_sync[SyncStages-1];

  // Bit phase runs continuously mod OverSample; decisions are made at the third mid-bit sample.
  assign w_cnt_nxt  = (r_tick_cnt == CntW'(OverSample - 1)) ? '0 : r_tick_cnt + 1'b1;
  assign w_mid_lo   = (w_cnt_nxt == CntW'(OverSample / 2 - 1));
  assign w_mid      = (w_cnt_nxt == CntW'(OverSample / 2));
  assign w_mid_hi   = (w_cnt_nxt == CntW'(OverSample / 2 + 1));
  assign w_maj      = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  assign w_ferr_fin = r_frame_err | ~w_maj;

  always_comb begin
    w_brk      = 1'b0;
    w_complete = 1'b0;
    if (w_tick && w_mid_hi) begin
      if (r_state == S_STOP1) begin
`ifdef UART_RX_BREAK_DET_EN
        w_brk = (r_shift == '0) && !(r_par_en && r_par_bit) && !w_maj;
`endif
        w_complete = !r_two_stop || w_brk;
      end else if (r_state == S_STOP2) begin
        w_complete = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_s0        <= 1'b1;
      r_s1        <= 1'b1;
      r_par_en    <= 1'b0;
      r_par_odd   <= 1'b0;
      r_two_stop  <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      r_par_bit   <= 1'b0;
`endif
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_brk       <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_tick) begin
        if (r_state != S_IDLE) begin
          r_tick_cnt <= w_cnt_nxt;
          if (w_mid_lo) r_s0 <= w_rx;
          if (w_mid)    r_s1 <= w_rx;
        end
        case (r_state)
          S_IDLE: if (!w_rx) begin
            r_state     <= S_START;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_par_en    <= i_parity_en;
            r_par_odd   <= i_parity_odd;
            r_two_stop  <= i_two_stop;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b1;
          end
          S_START: if (w_mid_hi) begin
            r_state <= w_maj ? S_IDLE : S_DATA;
            r_busy  <= ~w_maj;
          end
          S_DATA: if (w_mid_hi) begin
            r_shift   <= {w_maj, r_shift[DataLength-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BitW'(DataLength - 1))
              r_state <= r_par_en ? S_PARITY : S_STOP1;
          end
          S_PARITY: if (w_mid_hi) begin
            r_par_err <= ((^r_shift) ^ w_maj) != r_par_odd;
`ifdef UART_RX_BREAK_DET_EN
            r_par_bit <= w_maj;
`endif
            r_state   <= S_STOP1;
          end
          S_STOP1: if (w_mid_hi) begin
            r_frame_err <= w_ferr_fin;
`ifdef UART_RX_BREAK_DET_EN
            if (w_brk) begin
              r_state    <= S_WAIT_IDLE;
              r_tick_cnt <= '0;
            end else
`endif
            if (r_two_stop) begin
              r_state <= S_STOP2;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          S_STOP2: if (w_mid_hi) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
`ifdef UART_RX_BREAK_DET_EN
          // Needs OverSample consecutive high ticks before a new start bit may be hunted.
          S_WAIT_IDLE: begin
            if (!w_rx) begin
              r_tick_cnt <= '0;
            end else if (r_tick_cnt == CntW'(OverSample - 1)) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
`endif
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end

      if (w_complete) begin
        if (!r_valid || i_rx_ready) begin
          r_data  <= w_brk ? '0 : r_shift;
          r_perr  <= r_par_err;
          r_ferr  <= w_ferr_fin;
          r_brk   <= w_brk;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_rx_data    = r_data;
  assign o_rx_valid   = r_valid;
  assign o_parity_err = r_perr;
  assign o_frame_err  = r_ferr;
  assign o_break      = r_brk;
  assign o_overrun    = r_overrun;
  assign o_busy       = r_busy;
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: 8-bit and 7-bit instances driven bit-serially, expected words kept in a queue.
`timescale 1ns/1ps
module tb_uart_rx_core;
  localparam int BIT = 432;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst, rx8, rx7, par_en, par_odd, two_stop, ready8, ready7;
  logic [7:0] data8;
  logic [6:0] data7;
  logic valid8, perr8, ferr8, brk8, ovr8, busy8;
  logic valid7, perr7, ferr7, brk7, ovr7, busy7;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [8:0] data; logic perr, ferr, brk; } exp_t;
  exp_t sb[$];

  uart_rx_core #(.DataLength(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx8), .i_parity_en(par_en), .i_parity_odd(par_odd),
    .i_two_stop(two_stop), .o_rx_data(data8), .o_rx_valid(valid8), .i_rx_ready(ready8),
    .o_parity_err(perr8), .o_frame_err(ferr8), .o_break(brk8), .o_overrun(ovr8), .o_busy(busy8));

  uart_rx_core #(.DataLength(7)) dut7 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx7), .i_parity_en(par_en), .i_parity_odd(par_odd),
    .i_two_stop(two_stop), .o_rx_data(data7), .o_rx_valid(valid7), .i_rx_ready(ready7),
    .o_parity_err(perr7), .o_frame_err(ferr7), .o_break(brk7), .o_overrun(ovr7), .o_busy(busy7));

  int ovr_cnt = 0, acc_cnt = 0, acc_ferr = 0, acc_brk = 0, acc_nz = 0;
  always @(negedge clk) begin
    if (ovr8) ovr_cnt++;
    if (valid8 && ready8) begin
      acc_cnt++;
      if (ferr8) acc_ferr++;
      if (brk8) acc_brk++;
      if (data8 != 8'h00) acc_nz++;
    end
  end

  initial begin
    #(95000 * 20);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic b, input bit sel7);
    if (sel7) rx7 = b; else rx8 = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [8:0] d, input int n, input bit pen, input logic pbit,
                            input logic s1, input bit two, input logic s2, input bit sel7);
    @(posedge clk); #1;
    drive_bit(1'b0, sel7);
    for (int i = 0; i < n; i++) drive_bit(d[i], sel7);
    if (pen) drive_bit(pbit, sel7);
    drive_bit(s1, sel7);
    if (two) drive_bit(s2, sel7);
    if (sel7) rx7 = 1'b1; else rx8 = 1'b1;
  endtask

  task automatic wait_valid(input bit sel7, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if ((sel7 ? valid7 : valid8) === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  // Captures the presented word, then accepts it with a one-cycle ready pulse.
  task automatic accept(input bit sel7, output logic v, output logic [8:0] d,
                        output logic pe, output logic fe, output logic bk);
    @(negedge clk);
    v  = sel7 ? valid7 : valid8;
    d  = sel7 ? {2'b00, data7} : {1'b0, data8};
    pe = sel7 ? perr7 : perr8;
    fe = sel7 ? ferr7 : ferr8;
    bk = sel7 ? brk7 : brk8;
    @(posedge clk); #1;
    if (sel7) ready7 = 1'b1; else ready8 = 1'b1;
    @(posedge clk); #1;
    if (sel7) ready7 = 1'b0; else ready8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx8 = 1'b1; rx7 = 1'b1; ready8 = 1'b0; ready7 = 1'b0;
    par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (valid8 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid8); end
    checks++; if (data8 !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data8); end
    checks++; if ({perr8, ferr8, brk8, ovr8, busy8} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {perr8, ferr8, brk8, ovr8, busy8}); end
    checks++; if ({valid7, busy7, data7} !== 9'b0) begin
      errors++; $display("FAIL reset_dut7: got %b want 0", {valid7, busy7, data7}); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy8); end
  endtask

  task automatic check_word(input string name, input bit sel7);
    exp_t e;
    logic v, pe, fe, bk;
    logic [8:0] d;
    bit ok;
    wait_valid(sel7, 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_timeout: got no valid want valid", name); end
    e = sb.pop_front();
    accept(sel7, v, d, pe, fe, bk);
    checks++;
    if ({v, d, pe, fe, bk} !== {1'b1, e.data, e.perr, e.ferr, e.brk}) begin
      errors++;
      $display("FAIL %s: got v=%b d=%h pe=%b fe=%b bk=%b want v=1 d=%h pe=%b fe=%b bk=%b",
               name, v, d, pe, fe, bk, e.data, e.perr, e.ferr, e.brk);
    end
  endtask

  task automatic test_8n1();
    int bad = 0;
    bit ok;
    par_en = 1'b0; two_stop = 1'b0;
    sb.push_back('{9'h0A5, 1'b0, 1'b0, 1'b0});
    send_frame(9'h0A5, 8, 0, 0, 1, 0, 1, 0);
    wait_valid(0, 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL 8n1_valid: got 0 want 1"); end
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (valid8 !== 1'b1 || data8 !== 8'hA5) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL 8n1_hold: got %0d unstable cycles want 0", bad); end
    check_word("8n1_word", 0);
    @(negedge clk);
    checks++; if (valid8 !== 1'b0) begin errors++; $display("FAIL 8n1_clear: got %b want 0", valid8); end
  endtask

  task automatic test_parity();
    par_en = 1'b1; par_odd = 1'b0; two_stop = 1'b0;
    sb.push_back('{9'h037, 1'b1, 1'b0, 1'b0});
    send_frame(9'h037, 8, 1, 1'b0, 1, 0, 1, 0);
    check_word("even_bad", 0);
    sb.push_back('{9'h037, 1'b0, 1'b0, 1'b0});
    send_frame(9'h037, 8, 1, 1'b1, 1, 0, 1, 0);
    check_word("even_good", 0);
    par_odd = 1'b1;
    sb.push_back('{9'h037, 1'b0, 1'b0, 1'b0});
    send_frame(9'h037, 8, 1, 1'b0, 1, 0, 1, 0);
    check_word("odd_good", 0);
    par_en = 1'b0; par_odd = 1'b0;
  endtask

  task automatic test_two_stop_dl7();
    two_stop = 1'b1;
    sb.push_back('{9'h055, 1'b0, 1'b1, 1'b0});
    send_frame(9'h055, 7, 0, 0, 1'b1, 1, 1'b0, 1);
    check_word("dl7_stop2_bad", 1);
    sb.push_back('{9'h02A, 1'b0, 1'b0, 1'b0});
    send_frame(9'h02A, 7, 0, 0, 1'b1, 1, 1'b1, 1);
    check_word("dl7_stop2_good", 1);
    two_stop = 1'b0;
  endtask

  task automatic test_false_start();
    int idle_at = -1;
    bit seen = 1'b0;
    @(posedge clk); #1 rx8 = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL false_busy_high: got %b want 1", busy8); end
    rx8 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy8 === 1'b0 && idle_at < 0) idle_at = i;
      if (valid8 === 1'b1) seen = 1'b1;
    end
    checks++; if (idle_at < 0 || idle_at > 250) begin
      errors++; $display("FAIL false_busy_idle: got %0d cycles want <=250", idle_at); end
    checks++; if (seen) begin errors++; $display("FAIL false_no_valid: got valid want none"); end
  endtask

  task automatic test_back_to_back();
    int ovr0 = ovr_cnt;
    sb.push_back('{9'h011, 1'b0, 1'b0, 1'b0});
    send_frame(9'h011, 8, 0, 0, 1, 0, 1, 0);
    send_frame(9'h022, 8, 0, 0, 1, 0, 1, 0);
    repeat (10) @(posedge clk);
    checks++; if (ovr_cnt - ovr0 != 1) begin
      errors++; $display("FAIL b2b_overrun: got %0d pulses want 1", ovr_cnt - ovr0); end
    check_word("b2b_first", 0);
    @(negedge clk);
    checks++; if (valid8 !== 1'b0) begin errors++; $display("FAIL b2b_dropped: got %b want 0", valid8); end
  endtask

  task automatic test_midframe_reset();
    send_frame(9'h05A, 8, 0, 0, 1, 0, 1, 0);
    @(posedge clk); #1 rx8 = 1'b0;
    repeat (3 * BIT) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({valid8, busy8} !== 2'b00) begin
      errors++; $display("FAIL rst_mid: got valid,busy=%b want 00", {valid8, busy8}); end
    @(posedge clk); #1 rst = 1'b0; rx8 = 1'b1;
    repeat (BIT) @(posedge clk);
    sb.push_back('{9'h03C, 1'b0, 1'b0, 1'b0});
    send_frame(9'h03C, 8, 0, 0, 1, 0, 1, 0);
    check_word("after_rst", 0);
  endtask

  task automatic test_break();
    int w0, f0, b0, z0, w1, f1, b1, z1;
    @(posedge clk); #1;
    ready8 = 1'b1;
    w0 = acc_cnt; f0 = acc_ferr; b0 = acc_brk; z0 = acc_nz;
    rx8 = 1'b0;
    repeat (20 * BIT) @(posedge clk);
    #1;
    w1 = acc_cnt - w0; f1 = acc_ferr - f0; b1 = acc_brk - b0; z1 = acc_nz - z0;
    rx8 = 1'b1;
    repeat (12 * BIT) @(posedge clk);
    @(negedge clk);
`ifdef UART_RX_BREAK_DET_EN
    checks++; if (w1 != 1) begin errors++; $display("FAIL break_words: got %0d want 1", w1); end
    checks++; if (b1 != 1 || f1 != 1 || z1 != 0) begin
      errors++; $display("FAIL break_flags: got brk=%0d ferr=%0d nz=%0d want 1 1 0", b1, f1, z1); end
    checks++; if (acc_cnt - w0 != 1) begin
      errors++; $display("FAIL break_after_high: got %0d words want 1", acc_cnt - w0); end
`else
    checks++; if (w1 < 2) begin errors++; $display("FAIL held_low_words: got %0d want >=2", w1); end
    checks++; if (f1 != w1 || b1 != 0) begin
      errors++; $display("FAIL held_low_flags: got ferr=%0d brk=%0d want ferr=%0d brk=0", f1, b1, w1); end
`endif
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL break_busy: got %b want 0", busy8); end
    ready8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_two_stop_dl7();
    test_false_start();
    test_back_to_back();
    test_midframe_reset();
    test_break();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
